// File: rtl/alu_issue_queue.sv
// ----------------------------------------------------------------------------
// alu_issue_queue
//   Command/operand buffer in front of the 16-bit ALU. Commands are accepted
//   over a valid/ready handshake into a DEPTH-entry FIFO. The FIFO head is
//   driven onto the ALU input pins. The ALU's combinational outputs are
//   captured into a result register that has its own valid/ready handshake.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (cmd_ready = !full)
//   cmd_mode/select/carry_in   ALU command fields
//   cmd_a, cmd_b, cmd_tag      operands and opaque tag
//   alu_*  (out)               FIFO head fields to the ALU; all zero when empty
//   alu_out/carry_out/compare  ALU results (in)
//   res_valid / res_ready      result handshake
//   res_data/carry/compare/tag captured ALU result and the tag of its command
//   occupancy                  FIFO entry count
// ----------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_mode,
  input  logic [3:0]                     cmd_select,
  input  logic                           cmd_carry_in,
  input  logic [15:0]                    cmd_a,
  input  logic [15:0]                    cmd_b,
  input  logic [TAG_W-1:0]               cmd_tag,
  output logic                           alu_mode,
  output logic [3:0]                     alu_select,
  output logic                           alu_carry_in,
  output logic [15:0]                    alu_in_a,
  output logic [15:0]                    alu_in_b,
  input  logic [15:0]                    alu_out,
  input  logic                           alu_carry_out,
  input  logic                           alu_compare,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [15:0]                    res_data,
  output logic                           res_carry,
  output logic                           res_compare,
  output logic [TAG_W-1:0]               res_tag,
  output logic [$clog2(DEPTH):0]         occupancy
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              mode;
    logic [3:0]        select;
    logic              carry_in;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_carry_q, res_carry_d;
  logic                res_compare_q, res_compare_d;
  logic [TAG_W-1:0]    res_tag_q, res_tag_d;

  logic                full_c;
  logic                empty_c;
  logic                push_c;
  logic                issue_c;
  entry_t              head_c;
  entry_t              new_entry_c;

  // Handshake decode
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign push_c   = cmd_valid && !full_c;
  assign issue_c  = !empty_c && (!res_valid_q || res_ready);

  assign new_entry_c = '{mode: cmd_mode, select: cmd_select, carry_in: cmd_carry_in,
                         a: cmd_a, b: cmd_b, tag: cmd_tag};

  // Head comes only from stored entries, so the ALU pins never see cmd_* directly
  assign head_c = empty_c ? entry_t'('0) : mem_q[rd_ptr_q];

  assign alu_mode     = head_c.mode;
  assign alu_select   = head_c.select;
  assign alu_carry_in = head_c.carry_in;
  assign alu_in_a     = head_c.a;
  assign alu_in_b     = head_c.b;

  assign cmd_ready    = !full_c;
  assign occupancy    = count_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_carry    = res_carry_q;
  assign res_compare  = res_compare_q;
  assign res_tag      = res_tag_q;

  // Next-state: FIFO pointers, count, storage and result register
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_carry_d   = res_carry_q;
    res_compare_d = res_compare_q;
    res_tag_d     = res_tag_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = new_entry_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (issue_c) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      res_valid_d   = 1'b1;
      res_data_d    = alu_out;
      res_carry_d   = alu_carry_out;
      res_compare_d = alu_compare;
      res_tag_d     = head_c.tag;
    end else if (res_ready) begin
      // Consumed with nothing to replace it; data holds its last value
      res_valid_d = 1'b0;
    end

    case ({push_c, issue_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and result state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_carry_q   <= 1'b0;
      res_compare_q <= 1'b0;
      res_tag_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_carry_q   <= res_carry_d;
      res_compare_q <= res_compare_d;
      res_tag_q     <= res_tag_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while count > 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
  end

endmodule
